// File: rtl/param_rr_arbiter_if.sv
// rtl/param_rr_arbiter_if.sv - request/grant and shared datapath bus for param_rr_arbiter (lock lane under PARAMARB_LOCK_EN)
interface param_rr_arbiter_if #(
    parameter int N = 4,
    parameter int F = 3,
    parameter int K = 3
);
    localparam int W = F - K + 1;

    logic [N-1:0]   req;
`ifdef PARAMARB_LOCK_EN
    logic [N-1:0]   lock;
`endif
    logic [N*W-1:0] data;
    logic [N-1:0]   gnt;
    logic [N-1:0]   ack;
    logic [F:K]     dp_d;
    logic           dp_valid;
    logic           dp_ready;
    logic           busy;

`ifdef PARAMARB_LOCK_EN
    modport master (
        input  req, lock, data, dp_ready,
        output gnt, ack, dp_d, dp_valid, busy
    );
    modport slave (
        output req, lock, data, dp_ready,
        input  gnt, ack, dp_d, dp_valid, busy
    );
`else
    modport master (
        input  req, data, dp_ready,
        output gnt, ack, dp_d, dp_valid, busy
    );
    modport slave (
        output req, data, dp_ready,
        input  gnt, ack, dp_d, dp_valid, busy
    );
`endif
endinterface

// File: rtl/param_rr_arbiter.sv
// rtl/param_rr_arbiter.sv - burst-bounded round-robin arbiter for a shared datapath; optional lock via PARAMARB_LOCK_EN
module param_rr_arbiter #(
    parameter int N     = 4,
    parameter int F     = 3,
    parameter int K     = 3,
    parameter int BURST = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    param_rr_arbiter_if.master   bus
);
    localparam int W  = F - K + 1;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(BURST + 1);
    localparam logic [IW:0]   NL   = (IW+1)'(N);
    localparam logic [CW-1:0] LAST = CW'(BURST - 1);
    localparam logic [IW-1:0] TOP  = IW'(N - 1);

    typedef enum logic {IDLE, XFER} state_t;

    state_t        state, state_n;
    logic [IW-1:0] ptr, ptr_n;
    logic [IW-1:0] sel, sel_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [N-1:0]  gnt, gnt_n;

    logic [N-1:0]  rot;
    logic [IW-1:0] off;
    logic [IW:0]   sum;
    logic [IW-1:0] win;
    logic          found;
    logic          valid;
    logic          req_sel;
    logic          lock_sel;
    logic          at_last;
    logic [W-1:0]  dsel;

    assign valid   = (state == XFER);
    assign req_sel = bus.req[sel];
    assign at_last = (cnt == LAST);
`ifdef PARAMARB_LOCK_EN
    assign lock_sel = bus.lock[sel];
`else
    assign lock_sel = 1'b0;
`endif

    // Rotate requests so ptr lands on bit 0, take the lowest set bit, then map back to an index.
    always_comb begin
        rot   = N'({bus.req, bus.req} >> ptr);
        found = |bus.req;
        off   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) off = IW'(i);
        end
        sum = {1'b0, ptr} + {1'b0, off};
        win = (sum >= NL) ? IW'(sum - NL) : IW'(sum);
    end

    // Next-state: grant on entry, count accepted beats, release on burst end, request drop or abort.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        sel_n   = sel;
        cnt_n   = cnt;
        gnt_n   = gnt;
        case (state)
            IDLE: begin
                if (found) begin
                    state_n = XFER;
                    sel_n   = win;
                    gnt_n   = N'(1) << win;
                    cnt_n   = '0;
                    ptr_n   = (win == TOP) ? '0 : win + 1'b1;
                end
            end
            XFER: begin
                if (bus.dp_ready) begin
                    // A locked grant parks the counter at the last beat so dropping lock ends it cleanly.
                    if (lock_sel && at_last) cnt_n = cnt;
                    else                     cnt_n = cnt + 1'b1;
                    if (!req_sel || (at_last && !lock_sel)) begin
                        state_n = IDLE;
                        gnt_n   = '0;
                    end
                end else if (!req_sel) begin
                    state_n = IDLE;
                    gnt_n   = '0;
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
            end
        endcase
    end

    // State and grant registers; reset drops any beat in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            ptr   <= '0;
            sel   <= '0;
            cnt   <= '0;
            gnt   <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            sel   <= sel_n;
            cnt   <= cnt_n;
            gnt   <= gnt_n;
        end
    end

    // Live data mux keyed by the one-hot grant, so the bus reads zero whenever nothing is granted.
    always_comb begin
        dsel = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) dsel = bus.data[i*W +: W];
        end
    end

    assign bus.gnt      = gnt;
    assign bus.dp_valid = valid;
    assign bus.busy     = valid;
    assign bus.ack      = gnt & {N{valid & bus.dp_ready}};
    assign bus.dp_d     = dsel;
endmodule

// File: tb/tb_param_rr_arbiter.sv
// tb/tb_param_rr_arbiter.sv - self-checking bench for param_rr_arbiter
module tb_param_rr_arbiter;
    localparam int N = 4, F = 7, K = 0, BURST = 2, W = F - K + 1;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    param_rr_arbiter_if #(.N(N), .F(F), .K(K)) bus ();
    param_rr_arbiter #(.N(N), .F(F), .K(K), .BURST(BURST)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int checks = 0;
    int fails  = 0;

    int owner = -1;
    int beats = 0;
    int rrp   = 0;
    int acks_run = 0;
    int grant_q[$];
    int ackcnt_q[$];
    logic [N-1:0] prev_gnt = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] slice_of(input int idx);
        logic [W-1:0] r;
        r = '0;
        for (int j = 0; j < N; j++) if (j == idx) r = bus.data[j*W +: W];
        return r;
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] v);
        int r;
        r = -1;
        for (int j = 0; j < N; j++) if (v[j]) r = j;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: one owner at a time, at most BURST beats, rotating start after each winner.
    initial begin
        logic [N-1:0] exp_g, exp_a;
        logic [W-1:0] exp_d;
        logic         exp_v, lk;
        int           c;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                owner = -1; beats = 0; rrp = 0; acks_run = 0; prev_gnt = '0;
                chk("rst_gnt", 32'(bus.gnt), 32'd0);
                chk("rst_ack", 32'(bus.ack), 32'd0);
                chk("rst_dp_d", 32'(bus.dp_d), 32'd0);
                chk("rst_valid", 32'(bus.dp_valid), 32'd0);
                chk("rst_busy", 32'(bus.busy), 32'd0);
            end else begin
                exp_v = (owner >= 0);
                exp_g = exp_v ? (N'(1) << owner) : '0;
                exp_a = (exp_v && bus.dp_ready) ? exp_g : '0;
                exp_d = exp_v ? slice_of(owner) : '0;
                chk("gnt", 32'(bus.gnt), 32'(exp_g));
                chk("ack", 32'(bus.ack), 32'(exp_a));
                chk("dp_d", 32'(bus.dp_d), 32'(exp_d));
                chk("dp_valid", 32'(bus.dp_valid), 32'(exp_v));
                chk("busy", 32'(bus.busy), 32'(exp_v));

                if (prev_gnt == '0 && bus.gnt != '0) begin
                    grant_q.push_back(onehot_idx(bus.gnt));
                    acks_run = 0;
                end
                if (bus.ack != '0) acks_run++;
                if (prev_gnt != '0 && bus.gnt == '0) ackcnt_q.push_back(acks_run);
                prev_gnt = bus.gnt;

                if (owner < 0) begin
                    if (bus.req != '0) begin
                        for (int i = 0; i < N; i++) begin
                            c = (rrp + i) % N;
                            if (owner < 0 && bus.req[c]) owner = c;
                        end
                        beats = 0;
                        rrp = (owner + 1) % N;
                    end
                end else begin
                    lk = 1'b0;
`ifdef PARAMARB_LOCK_EN
                    lk = bus.lock[owner];
`endif
                    if (bus.dp_ready) begin
                        beats++;
                        if (!bus.req[owner] || (!lk && beats >= BURST)) owner = -1;
                    end else if (!bus.req[owner]) begin
                        owner = -1;
                    end
                end
            end
        end
    end

    initial begin
        rstn = 1'b0;
        bus.req = '0;
        bus.dp_ready = 1'b0;
        bus.data = {8'h44, 8'hA5, 8'h22, 8'h11};
`ifdef PARAMARB_LOCK_EN
        bus.lock = '0;
`endif
        repeat (3) tick();
        chk("init_gnt", 32'(bus.gnt), 32'd0);
        chk("init_busy", 32'(bus.busy), 32'd0);

        // Reset in the middle of a grant with a beat pending
        rstn = 1'b1;
        bus.req = 4'b0001;
        tick();
        chk("pre_rst_gnt", 32'(bus.gnt), 32'h1);
        tick();
        bus.dp_ready = 1'b1;
        #1;
        chk("pre_rst_ack", 32'(bus.ack), 32'h1);
        rstn = 1'b0;
        #1;
        chk("mid_rst_gnt", 32'(bus.gnt), 32'd0);
        chk("mid_rst_valid", 32'(bus.dp_valid), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_ack", 32'(bus.ack), 32'd0);
        chk("mid_rst_dp_d", 32'(bus.dp_d), 32'd0);
        tick();

        // Fairness with all requesting
        grant_q.delete();
        ackcnt_q.delete();
        rstn = 1'b1;
        bus.req = 4'b1111;
        bus.dp_ready = 1'b1;
        repeat (15) tick();
        bus.req = '0;
        tick();
        chk("fair_ngrants", 32'(grant_q.size()), 32'd5);
        chk("fair_ncounts", 32'(ackcnt_q.size()), 32'd5);
        if (grant_q.size() == 5) begin
            chk("fair_g0", 32'(grant_q[0]), 32'd0);
            chk("fair_g1", 32'(grant_q[1]), 32'd1);
            chk("fair_g2", 32'(grant_q[2]), 32'd2);
            chk("fair_g3", 32'(grant_q[3]), 32'd3);
            chk("fair_g4", 32'(grant_q[4]), 32'd0);
        end
        for (int i = 0; i < ackcnt_q.size(); i++) chk("fair_acks", 32'(ackcnt_q[i]), 32'd2);

        // Wrap from requester 3 back to 0
        grant_q.delete();
        ackcnt_q.delete();
        bus.req = 4'b1000;
        tick();
        bus.req = 4'b1001;
        repeat (3) tick();
        bus.req = '0;
        repeat (3) tick();
        chk("wrap_ngrants", 32'(grant_q.size()), 32'd2);
        if (grant_q.size() == 2) begin
            chk("wrap_first", 32'(grant_q[0]), 32'd3);
            chk("wrap_next", 32'(grant_q[1]), 32'd0);
        end

        // Stall with dp_ready low for five cycles
        grant_q.delete();
        ackcnt_q.delete();
        bus.req = 4'b0100;
        bus.dp_ready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("stall_gnt", 32'(bus.gnt), 32'h4);
            chk("stall_dp_d", 32'(bus.dp_d), 32'hA5);
            chk("stall_ack", 32'(bus.ack), 32'd0);
            tick();
        end
        bus.dp_ready = 1'b1;
        #1;
        chk("stall_first_ack", 32'(bus.ack), 32'h4);
        chk("stall_rel_dp_d", 32'(bus.dp_d), 32'hA5);
        repeat (2) tick();
        chk("stall_end_gnt", 32'(bus.gnt), 32'd0);
        bus.req = '0;
        tick();
        chk("stall_nacks", (ackcnt_q.size() > 0) ? 32'(ackcnt_q[0]) : 32'hFFFF, 32'd2);

        // Early release on the first accepted beat
        grant_q.delete();
        ackcnt_q.delete();
        bus.req = 4'b0010;
        bus.dp_ready = 1'b1;
        tick();
        chk("early_gnt", 32'(bus.gnt), 32'h2);
        bus.req = '0;
        #1;
        chk("early_ack", 32'(bus.ack), 32'h2);
        tick();
        chk("early_end_gnt", 32'(bus.gnt), 32'd0);
        tick();
        chk("early_nacks", (ackcnt_q.size() > 0) ? 32'(ackcnt_q[0]) : 32'hFFFF, 32'd1);

        // Abort while stalled
        bus.req = 4'b0010;
        bus.dp_ready = 1'b0;
        tick();
        chk("abort_gnt", 32'(bus.gnt), 32'h2);
        bus.req = '0;
        #1;
        chk("abort_ack", 32'(bus.ack), 32'd0);
        tick();
        chk("abort_end_gnt", 32'(bus.gnt), 32'd0);
        chk("abort_end_busy", 32'(bus.busy), 32'd0);
        tick();
        chk("abort_nacks", (ackcnt_q.size() > 1) ? 32'(ackcnt_q[1]) : 32'hFFFF, 32'd0);

`ifdef PARAMARB_LOCK_EN
        // Locked grant runs past BURST until lock drops
        grant_q.delete();
        ackcnt_q.delete();
        bus.req = 4'b0001;
        bus.lock = 4'b0001;
        bus.dp_ready = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("lock_ack", 32'(bus.ack), 32'h1);
            tick();
        end
        bus.lock = '0;
        #1;
        chk("lock_last_ack", 32'(bus.ack), 32'h1);
        tick();
        chk("lock_end_gnt", 32'(bus.gnt), 32'd0);
        bus.req = '0;
        tick();
        chk("lock_nacks", (ackcnt_q.size() > 0) ? 32'(ackcnt_q[0]) : 32'hFFFF, 32'd6);
`endif

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
